// File: rtl/uart_tx_sequencer.sv
// Latches a NUM_BYTES message on start and feeds it byte by byte to uart_transmitter
// over the Tx_EN/Tx_WR/Tx_DATA/Tx_BUSY handshake, reporting done and ack timeout.
module uart_tx_sequencer #(
    parameter int NUM_BYTES   = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] message,
    input  logic                   Tx_BUSY,
    output logic                   Tx_EN,
    output logic                   Tx_WR,
    output logic [7:0]             Tx_DATA,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [ACK_W-1:0] ACK_MAX  = ACK_W'(ACK_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [8*NUM_BYTES-1:0] msg_q,   msg_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [ACK_W-1:0]       ack_q,   ack_d;
    logic [GAP_W-1:0]       gap_q,   gap_d;
    logic                   en_q,    en_d;
    logic                   wr_q,    wr_d;
    logic [7:0]             data_q,  data_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic                   err_q,   err_d;

    logic                   advance;
    logic [ACK_W-1:0]       ack_next;
    logic [GAP_W-1:0]       gap_next;

    function automatic logic [7:0] byte_sel(input logic [8*NUM_BYTES-1:0] m,
                                            input logic [IDX_W-1:0]       i);
        logic [8*NUM_BYTES-1:0] sh;
        sh = m >> {i, 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [ACK_W-1:0] ack_sat_inc(input logic [ACK_W-1:0] v);
        return (v == ACK_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
        return (v == GAP_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        idx_d    = idx_q;
        ack_d    = ack_q;
        gap_d    = gap_q;
        en_d     = en_q;
        wr_d     = 1'b0;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        advance  = 1'b0;
        ack_next = ack_sat_inc(ack_q);
        gap_next = gap_sat_inc(gap_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = message;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    data_d  = message[7:0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_d    = 1'b1;
                data_d  = byte_sel(msg_q, idx_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                ack_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (Tx_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    ack_d = ack_next;
                    if (ack_next == ACK_MAX) begin
                        err_d   = 1'b1;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        data_d  = 8'h00;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                // Frame length depends on the transmitter baud rate, so no timeout here.
                if (!Tx_BUSY) begin
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_next;
                if (gap_next == GAP_MAX) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                data_d  = 8'h00;
                state_d = S_IDLE;
            end else begin
                // Later bytes skip LOAD: the transmitter is already enabled.
                idx_d   = idx_q + 1'b1;
                wr_d    = 1'b1;
                data_d  = byte_sel(msg_q, idx_q + 1'b1);
                state_d = S_WRITE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            gap_q   <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Tx_EN   = en_q;
    assign Tx_WR   = wr_q;
    assign Tx_DATA = data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = err_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: a 4-byte instance with no gap and a
// 1-byte instance with a 3-cycle gap, each driven by a simple Tx_BUSY responder.
module tb_uart_tx_sequencer;

    localparam int N0 = 4, G0 = 0, T0 = 64;
    localparam int N1 = 1, G1 = 3, T1 = 4;

    localparam int S_DONE0 = 0, S_WR0 = 1, S_BUSY0 = 2, S_NBUSY0 = 3;
    localparam int S_DONE1 = 4, S_WR1 = 5, S_BUSY1 = 6, S_NBUSY1 = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] msg0;
    logic [7:0]  msg1;
    logic        busy0 = 1'b0, busy1 = 1'b0;
    logic        en0, wr0, bsy0, done0, err0;
    logic        en1, wr1, bsy1, done1, err1;
    logic [7:0]  data0, data1;
    logic        me0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int bc0 = 0, bc1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sequencer #(.NUM_BYTES(N0), .GAP_CYCLES(G0), .ACK_TIMEOUT(T0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .message(msg0), .Tx_BUSY(busy0),
        .Tx_EN(en0), .Tx_WR(wr0), .Tx_DATA(data0), .busy(bsy0), .done(done0), .error(err0)
    );

    uart_tx_sequencer #(.NUM_BYTES(N1), .GAP_CYCLES(G1), .ACK_TIMEOUT(T1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .message(msg1), .Tx_BUSY(busy1),
        .Tx_EN(en1), .Tx_WR(wr1), .Tx_DATA(data1), .busy(bsy1), .done(done1), .error(err1)
    );

    // Transmitter stand-in: busy rises the clock after Tx_WR and stays high 10 clocks.
    always @(posedge clk) begin
        if (!me0) begin
            busy0 <= 1'b0;
            bc0   <= 0;
        end else if (wr0) begin
            busy0 <= 1'b1;
            bc0   <= 10;
        end else if (bc0 > 1) begin
            bc0 <= bc0 - 1;
        end else if (bc0 == 1) begin
            bc0   <= 0;
            busy0 <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (wr1) begin
            busy1 <= 1'b1;
            bc1   <= 10;
        end else if (bc1 > 1) begin
            bc1 <= bc1 - 1;
        end else if (bc1 == 1) begin
            bc1   <= 0;
            busy1 <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for instance 0.
    logic [7:0] exp_q[$];
    logic [7:0] last_wr0 = 8'h00;
    logic       prev_b0 = 1'b0;
    logic       fall_v0 = 1'b0;
    int         fall_cyc0 = 0;

    always @(negedge clk) begin
        if (wr0) begin
            chk("wr_expected_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("tx_data_on_wr", data0, exp_q.pop_front());
            if (fall_v0) chk("wr_after_busy_fall", cyc - fall_cyc0, G0 + 1);
            fall_v0  <= 1'b0;
            last_wr0 <= data0;
        end
        if (busy0 && en0 && !wr0) chk("tx_data_stable", data0, last_wr0);
        if (done0) begin
            chk("done_while_busy", bsy0, 0);
            fall_v0 <= 1'b0;
        end
        if (prev_b0 && !busy0 && en0) begin
            fall_cyc0 <= cyc;
            fall_v0   <= 1'b1;
        end
        prev_b0 <= busy0;
    end

    function automatic logic sig(input int which);
        case (which)
            S_DONE0:  return done0;
            S_WR0:    return wr0;
            S_BUSY0:  return busy0;
            S_NBUSY0: return !busy0;
            S_DONE1:  return done1;
            S_WR1:    return wr1;
            S_BUSY1:  return busy1;
            S_NBUSY1: return !busy1;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < lim);
        chk(name, sig(which), 1);
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_en"},   en0,   0);
        chk({tag, "_wr"},   wr0,   0);
        chk({tag, "_data"}, data0, 0);
        chk({tag, "_busy"}, bsy0,  0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_err"},  err0,  0);
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, "_en"},   en1,   0);
        chk({tag, "_wr"},   wr1,   0);
        chk({tag, "_data"}, data1, 0);
        chk({tag, "_busy"}, bsy1,  0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_err"},  err1,  0);
    endtask

    task automatic push_msg0(input logic [31:0] m);
        for (int i = 0; i < 4; i++) exp_q.push_back(m[8*i +: 8]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int n;
        int fall;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        msg0   = 32'h0;
        msg1   = 8'h0;
        me0    = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle0("rst0");
        chk_idle1("rst1");
        reset = 1'b0;
        @(negedge clk);
        chk_idle0("idle0");
        chk_idle1("idle1");

        // Four-byte message; a start pulse and new payload mid-message are ignored.
        msg0 = 32'h44434241;
        push_msg0(msg0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("A_load_en", en0, 1);
        chk("A_load_busy", bsy0, 1);
        chk("A_load_data", data0, 8'h41);
        chk("A_load_wr", wr0, 0);
        @(negedge clk);
        chk("A_write_strobe", wr0, 1);
        @(negedge clk);
        chk("A_strobe_one_cycle", wr0, 0);
        wait_for("A_ack", S_BUSY0, 20);
        msg0   = 32'hDEADBEEF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_for("A_done", S_DONE0, 300);
        chk("A_done_busy", bsy0, 0);
        chk("A_done_en", en0, 0);
        chk("A_done_err", err0, 0);
        chk("A_done_data", data0, 0);
        chk("A_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("A_done_pulse", done0, 0);
        chk("A_stays_idle", bsy0, 0);

        // Ack timeout with Tx_BUSY held low.
        me0  = 1'b0;
        msg0 = 32'h88776655;
        exp_q.push_back(8'h55);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_for("T_wr", S_WR0, 5);
        repeat (T0) @(negedge clk);
        chk("T_err_not_yet", err0, 0);
        chk("T_en_still", en0, 1);
        @(negedge clk);
        chk("T_err_set", err0, 1);
        chk("T_en_drop", en0, 0);
        chk("T_busy_drop", bsy0, 0);
        chk("T_no_done", done0, 0);
        @(negedge clk);
        chk("T_err_sticky", err0, 1);
        me0  = 1'b1;
        msg0 = 32'h04030201;
        push_msg0(msg0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("T_err_cleared", err0, 0);
        chk("T_restart_data", data0, 8'h01);
        wait_for("T_done", S_DONE0, 300);
        chk("T_done_err", err0, 0);
        chk("T_queue_empty", exp_q.size(), 0);

        // Reset during WAIT_DONE of byte 2, then restart from byte 0.
        msg0 = 32'hA3A2A1A0;
        push_msg0(msg0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        nwr = 0;
        n   = 0;
        while (nwr < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (wr0) nwr++;
        end
        chk("R_three_writes", nwr, 3);
        @(negedge clk);
        @(negedge clk);
        chk("R_in_wait_done", busy0 & en0, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_idle0("R_reset");
        reset = 1'b0;
        exp_q.delete();
        wait_for("R_tx_idle", S_NBUSY0, 50);
        msg0 = 32'hB3B2B1B0;
        push_msg0(msg0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("R_restart_data", data0, 8'hB0);
        chk("R_restart_en", en0, 1);
        wait_for("R_done", S_DONE0, 300);
        chk("R_queue_empty", exp_q.size(), 0);

        // Single-byte instance with start held high through completion.
        msg1   = 8'h5A;
        start1 = 1'b1;
        wait_for("S_wr", S_WR1, 10);
        chk("S_data", data1, 8'h5A);
        wait_for("S_busy", S_BUSY1, 5);
        wait_for("S_fall", S_NBUSY1, 30);
        fall = cyc;
        wait_for("S_done", S_DONE1, 30);
        chk("S_gap_timing", cyc - fall, G1 + 1);
        chk("S_done_busy", bsy1, 0);
        chk("S_done_en", en1, 0);
        chk("S_done_err", err1, 0);
        @(negedge clk);
        chk("S_restart_busy", bsy1, 1);
        chk("S_restart_en", en1, 1);
        chk("S_restart_data", data1, 8'h5A);
        chk("S_restart_done_low", done1, 0);
        start1 = 1'b0;
        wait_for("S_wr2", S_WR1, 5);
        chk("S_data2", data1, 8'h5A);
        wait_for("S_done2", S_DONE1, 60);
        chk("S_done2_err", err1, 0);
        @(negedge clk);
        chk("S_final_idle", bsy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
